intersection_traffic_model: RTL

//  Closed-loop environment model for the intersection light controller. Watches its light

---
 rtl/intersection_traffic_model.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/intersection_traffic_model.sv
// intersection_traffic_model
//   Closed-loop environment for the intersection light controller. It watches the controller's
//   lamps, keeps car queues for La Rue and Orchard plus a single pedestrian, and drives the
//   controller's sensor inputs. Arrivals come from a 16-bit Galois LFSR sampled once per
//   simulated second (tick). Illegal lamp combinations are latched for on-board self-check.
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   i_enable                     1 = simulated time advances
//   i_la_rue_* / i_orchard_*     controller lamps (green/yellow/red) per road
//   i_pedestrian_walk/stop       controller pedestrian lamps
//   o_la_rue_sensor              car waiting on La Rue (registered, 1 clk lag)
//   o_orchard_sensor             car waiting on Orchard (registered, 1 clk lag)
//   o_pedestrian_sensor          active-low push button, 0 while pressing
//   o_la_rue_queue/orchard_queue cars queued per road
//   o_ped_waiting                pedestrian is pressing or waiting
//   o_tick                       one-cycle pulse per simulated second
//   o_cars_passed                total departures, wrapping
//   o_overflow                   sticky: arrival dropped at a full queue
//   o_conflict_error             sticky: illegal lamp combination seen
module intersection_traffic_model #(
  parameter int unsigned TICK_DIV     = 25000000,
  parameter int unsigned QW           = 4,
  parameter int unsigned QUEUE_MAX    = 15,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [7:0]  LA_RUE_RATE  = 8'd64,
  parameter logic [7:0]  ORCHARD_RATE = 8'd32,
  parameter logic [7:0]  PED_RATE     = 8'd16,
  parameter int unsigned DEPART_TICKS = 2,
  parameter int unsigned PRESS_CYCLES = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_enable,
  input  logic          i_la_rue_green,
  input  logic          i_la_rue_yellow,
  input  logic          i_la_rue_red,
  input  logic          i_orchard_green,
  input  logic          i_orchard_yellow,
  input  logic          i_orchard_red,
  input  logic          i_pedestrian_walk,
  input  logic          i_pedestrian_stop,
  output logic          o_la_rue_sensor,
  output logic          o_orchard_sensor,
  output logic          o_pedestrian_sensor,
  output logic [QW-1:0] o_la_rue_queue,
  output logic [QW-1:0] o_orchard_queue,
  output logic          o_ped_waiting,
  output logic          o_tick,
  output logic [15:0]   o_cars_passed,
  output logic          o_overflow,
  output logic          o_conflict_error
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW    = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESS_LAST = PW'(PRESS_CYCLES - 1);
  localparam logic [QW-1:0]    Q_MAX      = QW'(QUEUE_MAX);
  localparam logic [7:0]       DEP_LAST   = 8'(DEPART_TICKS - 1);

  localparam logic [1:0] PED_IDLE  = 2'd0;
  localparam logic [1:0] PED_PRESS = 2'd1;
  localparam logic [1:0] PED_WAIT  = 2'd2;
  localparam logic [1:0] PED_CROSS = 2'd3;

  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_lfsr;
  logic [QW-1:0]    r_queue [2];
  logic [7:0]       r_dep_cnt [2];
  logic [1:0]       r_sensor;
  logic [15:0]      r_cars_passed;
  logic             r_overflow;
  logic             r_conflict;
  logic [1:0]       r_ped_state;
  logic [PW-1:0]    r_press_cnt;

  logic             w_tick;
  logic [15:0]      w_lfsr_step;
  logic [1:0]       w_go;
  logic [1:0]       w_arr;
  logic [1:0]       w_dep;
  logic [1:0]       w_drop;
  logic             w_arr_ped;
  logic             w_conflict;
  logic [QW-1:0]    w_queue_d [2];
  logic [7:0]       w_dep_cnt_d [2];
  logic [1:0]       w_ped_state_d;
  logic [PW-1:0]    w_press_cnt_d;
  logic             w_unused_lamps;

  // Red and stop lamps carry no information beyond green/yellow/walk.
  assign w_unused_lamps = ^{i_la_rue_red, i_orchard_red, i_pedestrian_stop};

  assign w_tick      = i_enable & reset_n & (r_div == DIV_LAST);
  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_go        = {i_orchard_green | i_orchard_yellow, i_la_rue_green | i_la_rue_yellow};
  assign w_conflict  = (w_go[0] & w_go[1]) | (i_pedestrian_walk & (|w_go));
  // Arrival decisions look at the LFSR value before this tick advances it.
  assign w_arr_ped   = w_tick & (r_lfsr[11:4] < PED_RATE);

  // Per-road departure pacing and queue update; index 0 = La Rue, 1 = Orchard.
  always_comb begin
    w_arr[0] = w_tick & (r_lfsr[7:0] < LA_RUE_RATE);
    w_arr[1] = w_tick & (r_lfsr[15:8] < ORCHARD_RATE);
    for (int i = 0; i < 2; i++) begin
      w_dep[i]       = 1'b0;
      w_drop[i]      = 1'b0;
      w_dep_cnt_d[i] = r_dep_cnt[i];
      w_queue_d[i]   = r_queue[i];
      if (!w_go[i] || (r_queue[i] == '0)) begin
        w_dep_cnt_d[i] = '0;
      end else if (w_tick) begin
        if (r_dep_cnt[i] == DEP_LAST) begin
          w_dep[i]       = 1'b1;
          w_dep_cnt_d[i] = '0;
        end else begin
          w_dep_cnt_d[i] = r_dep_cnt[i] + 8'd1;
        end
      end
      if (w_arr[i] && !w_dep[i]) begin
        if (r_queue[i] == Q_MAX) begin
          w_drop[i] = 1'b1;
        end else begin
          w_queue_d[i] = r_queue[i] + QW'(1);
        end
      end else if (w_dep[i] && !w_arr[i]) begin
        w_queue_d[i] = r_queue[i] - QW'(1);
      end
    end
  end

  // Pedestrian: press the button for a fixed number of clocks, then wait for walk.
  always_comb begin
    w_ped_state_d = r_ped_state;
    w_press_cnt_d = r_press_cnt;
    case (r_ped_state)
      PED_IDLE: begin
        if (w_arr_ped) begin
          w_ped_state_d = PED_PRESS;
          w_press_cnt_d = '0;
        end
      end
      PED_PRESS: begin
        if (r_press_cnt == PRESS_LAST) begin
          w_ped_state_d = PED_WAIT;
        end else begin
          w_press_cnt_d = r_press_cnt + PW'(1);
        end
      end
      PED_WAIT: begin
        if (i_pedestrian_walk) w_ped_state_d = PED_CROSS;
      end
      default: begin
        if (!i_pedestrian_walk) w_ped_state_d = PED_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div         <= '0;
      r_lfsr        <= LFSR_SEED;
      r_sensor      <= '0;
      r_cars_passed <= '0;
      r_overflow    <= 1'b0;
      r_conflict    <= 1'b0;
      r_ped_state   <= PED_IDLE;
      r_press_cnt   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_queue[i]   <= '0;
        r_dep_cnt[i] <= '0;
      end
    end else begin
      if (i_enable) r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      // A zero LFSR would lock up; reload the seed instead of stepping.
      if (w_tick) r_lfsr <= (r_lfsr == '0) ? LFSR_SEED : w_lfsr_step;
      for (int i = 0; i < 2; i++) begin
        r_queue[i]   <= w_queue_d[i];
        r_dep_cnt[i] <= w_dep_cnt_d[i];
        r_sensor[i]  <= (r_queue[i] != '0);
      end
      r_cars_passed <= r_cars_passed + 16'(w_dep[0]) + 16'(w_dep[1]);
      r_overflow    <= r_overflow | (|w_drop);
      r_conflict    <= r_conflict | w_conflict;
      r_ped_state   <= w_ped_state_d;
      r_press_cnt   <= w_press_cnt_d;
    end
  end

  assign o_la_rue_sensor     = r_sensor[0];
  assign o_orchard_sensor    = r_sensor[1];
  assign o_pedestrian_sensor = (r_ped_state != PED_PRESS);
  assign o_ped_waiting       = (r_ped_state == PED_PRESS) | (r_ped_state == PED_WAIT);
  assign o_la_rue_queue      = r_queue[0];
  assign o_orchard_queue     = r_queue[1];
  assign o_tick              = w_tick;
  assign o_cars_passed       = r_cars_passed;
  assign o_overflow          = r_overflow;
  assign o_conflict_error    = r_conflict;

endmodule
